// File: rtl/reaction_timer_pkg.sv
// Shared types, widths and BCD helpers for the reaction timer.
// A 4-digit BCD time in ms is displayed and compared without binary conversion.
package reaction_pkg;

    localparam int unsigned BCD_DIGITS     = 4;
    localparam int unsigned BCD_W          = 4 * BCD_DIGITS;
    localparam int unsigned MAX_MS_DEFAULT = 9999;

    typedef enum logic [2:0] {
        StIdle,
        StCountdown,
        StTiming,
        StResult,
        StFalse,
        StTimeout
    } state_e;

    // Elaboration-time conversion of the saturation constant only.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned value);
        logic [BCD_W-1:0] bcd;
        int unsigned      rem;
        bcd = '0;
        rem = value;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            bcd[i*4 +: 4] = 4'(rem % 10);
            rem           = rem / 10;
        end
        return bcd;
    endfunction

    // Strict less-than, decided by the first differing digit from the MSD down.
    function automatic logic bcd_less(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
        logic less;
        logic found;
        less  = 1'b0;
        found = 1'b0;
        for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
            if (!found && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                less  = (a[i*4 +: 4] < b[i*4 +: 4]);
                found = 1'b1;
            end
        end
        return less;
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Player/countdown event inputs and display/status outputs of the reaction timer.
// slave is the timer side, master is the side driving the events.
interface reaction_timer_if;

    logic                       tick_1ms;
    logic                       countdown_in_action;
    logic                       countdown_done;
    logic                       btn_press;
    logic                       clear_best;
    logic [reaction_pkg::BCD_W-1:0] time_bcd;
    logic [reaction_pkg::BCD_W-1:0] best_bcd;
    logic                       best_valid;
    logic                       timing_active;
    logic                       result_valid;
    logic                       result_pulse;
    logic                       false_start;
    logic                       timeout;

    modport master (
        output tick_1ms, countdown_in_action, countdown_done, btn_press, clear_best,
        input  time_bcd, best_bcd, best_valid, timing_active, result_valid, result_pulse,
               false_start, timeout
    );

    modport slave (
        input  tick_1ms, countdown_in_action, countdown_done, btn_press, clear_best,
        output time_bcd, best_bcd, best_valid, timing_active, result_valid, result_pulse,
               false_start, timeout
    );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and saturation at MAX_VAL.
module bcd_counter4
    import reaction_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_VAL = to_bcd(MAX_MS_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [BCD_W-1:0] count,
    output logic             at_max
);

    logic [BCD_W-1:0] count_q;
    logic [BCD_W-1:0] count_inc;
    logic             carry;

    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (carry) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !at_max) begin
            count_q <= count_inc;
        end
    end

    assign at_max = (count_q == MAX_VAL);
    assign count  = count_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game controller: times the player's press after GO in BCD ms
// and keeps the best (lowest) valid score.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int unsigned MAX_MS = MAX_MS_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    reaction_timer_if.slave bus
);

    state_e           state_q, state_d;
    logic             cnt_clear, cnt_en, cnt_at_max;
    logic             result_entry;
    logic [BCD_W-1:0] cnt_value;
    logic [BCD_W-1:0] best_q, best_d;
    logic             best_valid_q, best_valid_d;
    logic             timing_active_q, result_valid_q, result_pulse_q;
    logic             false_start_q, timeout_q;

    bcd_counter4 #(
        .MAX_VAL(to_bcd(MAX_MS))
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .enable(cnt_en),
        .count (cnt_value),
        .at_max(cnt_at_max)
    );

    always_comb begin
        state_d      = state_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        result_entry = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.countdown_in_action) begin
                    state_d   = StCountdown;
                    cnt_clear = 1'b1;
                end else if (bus.countdown_done) begin
                    state_d   = StTiming;
                    cnt_clear = 1'b1;
                end
            end
            StCountdown: begin
                // An early press beats a coincident GO.
                if (bus.btn_press) begin
                    state_d = StFalse;
                end else if (bus.countdown_done) begin
                    state_d   = StTiming;
                    cnt_clear = 1'b1;
                end
            end
            StTiming: begin
                if (bus.btn_press) begin
                    state_d      = StResult;
                    result_entry = 1'b1;
                end else if (bus.tick_1ms) begin
                    if (cnt_at_max) begin
                        state_d = StTimeout;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            StResult, StFalse, StTimeout: begin
                if (bus.countdown_in_action) begin
                    state_d   = StCountdown;
                    cnt_clear = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear first so a coincident result entry always becomes the new best.
    always_comb begin
        best_d       = best_q;
        best_valid_d = best_valid_q;
        if (bus.clear_best) begin
            best_d       = '0;
            best_valid_d = 1'b0;
        end
        if (result_entry && (!best_valid_d || bcd_less(cnt_value, best_d))) begin
            best_d       = cnt_value;
            best_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            best_q          <= '0;
            best_valid_q    <= 1'b0;
            timing_active_q <= 1'b0;
            result_valid_q  <= 1'b0;
            result_pulse_q  <= 1'b0;
            false_start_q   <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            best_q          <= best_d;
            best_valid_q    <= best_valid_d;
            timing_active_q <= (state_d == StTiming);
            result_valid_q  <= (state_d == StResult);
            result_pulse_q  <= result_entry;
            false_start_q   <= (state_d == StFalse);
            timeout_q       <= (state_d == StTimeout);
        end
    end

    assign bus.time_bcd      = cnt_value;
    assign bus.best_bcd      = best_q;
    assign bus.best_valid    = best_valid_q;
    assign bus.timing_active = timing_active_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.result_pulse  = result_pulse_q;
    assign bus.false_start   = false_start_q;
    assign bus.timeout       = timeout_q;

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: tick_1ms  input  1  one-clk enable pulse, once per millisecond.
REQ-004 SHALL have port: countdown_in_action  input  1  level, upstream countdown running.
REQ-005 SHALL have port: countdown_done  input  1  one-clk pulse, countdown finished ("GO").
REQ-006 SHALL have port: btn_press  input  1  one-clk debounced player press pulse.
REQ-007 SHALL have port: clear_best  input  1  one-clk pulse, forget best score.
REQ-008 SHALL have port: time_bcd  output  16  current or latched reaction time, 4 BCD digits, ms, digit 3 = MSD.
REQ-009 SHALL have port: best_bcd  output  16  best (lowest) valid result, BCD.
REQ-010 SHALL have port: best_valid  output  1  best_bcd holds a real score.
REQ-011 SHALL have port: timing_active  output  1  high in TIMING state.
REQ-012 SHALL have port: result_valid  output  1  high in RESULT state.
REQ-013 SHALL have port: result_pulse  output  1  one-clk pulse on entry to RESULT.
REQ-014 SHALL have port: false_start  output  1  high in FALSE state.
REQ-015 SHALL have port: timeout  output  1  high in TIMEOUT state.
REQ-016 SHALL have parameter: MAX_MS, default 9999, saturation value of time counter (BCD-representable).

Function
REQ-017 SHALL implement FSM states IDLE, COUNTDOWN, TIMING, RESULT, FALSE, TIMEOUT; all outputs registered.
REQ-018 IDLE/RESULT/FALSE/TIMEOUT: countdown_in_action=1 SHALL go to COUNTDOWN next clk and clear time_bcd to 0000.
REQ-019 IDLE or COUNTDOWN: countdown_done=1 with btn_press=0 SHALL go to TIMING, time_bcd=0000.
REQ-020 COUNTDOWN: btn_press=1 SHALL go to FALSE, including when countdown_done=1 in same clk (press wins).
REQ-021 IDLE: btn_press SHALL be ignored.
REQ-022 TIMING: each tick_1ms SHALL increment time_bcd by 1 with decimal carry per digit (9->0, carry up).
REQ-023 TIMING: btn_press SHALL go to RESULT, freezing time_bcd at its pre-edge value; a simultaneous tick_1ms SHALL NOT be counted.
REQ-024 TIMING: tick_1ms when time_bcd==MAX_MS and btn_press=0 SHALL go to TIMEOUT, time_bcd held at MAX_MS (no wrap).
REQ-025 result_pulse SHALL be high exactly the first clk result_valid is high.
REQ-026 On entry to RESULT, best_bcd SHALL load time_bcd if best_valid=0 or time_bcd<best_bcd; best_valid SHALL set; ties SHALL NOT reload.
REQ-027 clear_best SHALL clear best_valid and set best_bcd=0000 next clk; if coincident with RESULT entry, the new result SHALL become best, best_valid=1.
REQ-028 FALSE and TIMEOUT SHALL NOT update best_bcd/best_valid.
REQ-029 btn_press and tick_1ms SHALL be ignored in RESULT, FALSE, TIMEOUT.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, time_bcd=0000, best_bcd=0000, best_valid=0, all status outputs and result_pulse=0.
REQ-031 rst mid-TIMING SHALL discard the running time; no result or best update SHALL occur.
REQ-032 After rst release, first state change SHALL require a rising clk edge with stimulus per REQ-018/019.

Structure
REQ-033 Shared package reaction_pkg SHALL hold the state enumeration, BCD_DIGITS=4 and default MAX_MS.
REQ-034 A sub-module bcd_counter4 (clear, enable, saturate-at-max, at_max flag) SHALL implement the time counter.
REQ-035 Best-score compare SHALL be BCD digit-wise from MSD, no binary conversion.

Verification
REQ-036 Normal: in_action 1 -> done pulse, 237 ticks, press -> time_bcd=0237, result_pulse one clk, best_bcd=0237, best_valid=1.
REQ-037 Best update: second round 0412 -> best stays 0237; third round 0150 -> best 0150; tie 0150 -> no reload.
REQ-038 False start: press during COUNTDOWN, and press coincident with done -> false_start=1, best unchanged.
REQ-039 Timeout: 9999 ticks, 10000th tick -> timeout=1, time_bcd=9999; later ticks/press ignored.
REQ-040 Edges: press+tick same clk at 0099 -> time_bcd=0099; clear_best coincident with RESULT entry -> best=new result, best_valid=1.
REQ-041 Reset: assert rst at time_bcd=0050 in TIMING -> all outputs 0 immediately (before next clk), state IDLE.
